hyperram_responder: RTL and testbench
=====================================

# hyperram_responder

Synthesizable HyperBus responder emulating a single-die HyperRAM behind one chip select, so an FPGA build can exercise the SoC's HyperBus controller without an external memory on the FMC card. It oversamples CK/CS#/DQ/RWDS with the system clock, decodes the command-address (CA) phase, enforces fixed 2x initial latency, and serves linear bursts from a single-port word SRAM. It also serves the ID0/ID1 and CR0 register space.

## Interface
- AddrWidth, 20: word-address bits of the backing SRAM; addresses wrap modulo 2^AddrWidth.
- LatencyClks, 6: initial latency in CK clocks; always doubled.
- Id0, 16'h0c81: value returned for register word 0x000.
- Id1, 16'h0001: value returned for register word 0x001.
- Cr0Reset, 16'h8f1f: reset value of CR0 (register word 0x800).
- clk_i  in  1  oversampling clock; one clock domain; each CK half-period ≥ 4 clk_i cycles.
- rst_ni  in  1  asynchronous active-low reset.
- hyper_ck_i  in  1  HyperBus CK; CK# unused.
- hyper_cs_ni  in  1  chip select, active low.
- hyper_dq_i  in  8  DQ from pad.
- hyper_dq_o  out  8  DQ to pad.
- hyper_dq_oe_o  out  1  DQ output enable.
- hyper_rwds_i  in  1  RWDS from pad (write mask).
- hyper_rwds_o  out  1  RWDS to pad.
- hyper_rwds_oe_o  out  1  RWDS output enable.
- mem_req_o  out  1  SRAM request, one cycle.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  AddrWidth  SRAM word address.
- mem_wdata_o  out  16  write word, [15:8] = first byte on bus.
- mem_be_o  out  2  byte enables, [1] = upper byte.
- mem_rdata_i  in  16  read data, valid exactly 1 cycle after a read request.
- cr0_o  out  16  current CR0 value.

## Operation
- Input conditioning: CK, CS#, DQ and RWDS all pass through the same 2-flop synchronizer. A CK edge is a change between the last two synchronized CK samples. The DQ/RWDS values sampled with that edge are used.
- FSM states: IDLE, CA, LATENCY, WDATA, RDATA.
- IDLE -> CA on synchronized CS# low. Drive RWDS = 1 with oe = 1 to signal 2x latency.
- CA: capture 6 bytes on 6 consecutive edges, MSB byte first, into ca[47:0].
  - ca[47] = R/W# (1 = read); ca[46] = register space.
  - ca[45] (burst type) is ignored; all bursts are linear.
  - Word address = {ca[44:16], ca[2:0]}, truncated to AddrWidth.
- After the 6th CA byte:
  - memory access, or register read -> LATENCY;
  - register write -> WDATA directly (zero latency).
- LATENCY: ignore 4*LatencyClks edges, then move to WDATA or RDATA.
  - Read: RWDS = 0, oe = 1. Write: RWDS oe = 0.
- WDATA: even edge -> upper byte, odd edge -> lower byte. RWDS = 1 masks that byte.
  - After each odd edge, issue one write: be = {~mask_hi, ~mask_lo}, then address + 1.
  - The request is suppressed when be = 0.
  - Register write to word 0x800 loads cr0; writes to any other register address are dropped.
- RDATA:
  - Issue an SRAM read on entry; latch the result 1 cycle later.
  - On each edge, drive the next byte (upper byte first) and toggle RWDS, starting 0 -> 1. dq_oe = 1.
  - After the lower byte is driven, increment the address and issue the next read.
  - Register reads return Id0, Id1 or cr0 for words 0x000, 0x001, 0x800; all other register words return 0.
- Address wraps from 2^AddrWidth-1 to 0.
- CS# rising edge, in any state: go to IDLE the same cycle and clear all oe.
  - A write word with only its upper byte captured commits with be = 2'b10 (or no request if masked).
  - An outstanding read is discarded.

## Timing
- Reset values: dq_o = 0, dq_oe = 0, rwds_o = 0, rwds_oe = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_be = 0, cr0_o = Cr0Reset, FSM = IDLE.
- Pad outputs update exactly 1 clk_i after edge detection, i.e. 3 clk_i after the raw CK transition. The controller samples read data against RWDS.
- Write request: 1 clk_i after the odd-edge detection.
- Read prefetch completes ≥ 2 clk_i before the next edge, given the 4-cycle half-period rule.
- CS# low→high→low within one CK half-period is not supported.

## Structure
- Package hyperram_responder_pkg holds: the FSM enum, the CA bit-position constants, register word constants (RegId0 = 0x000, RegId1 = 0x001, RegCr0 = 0x800), and the latency multiplier.
- One sub-module, hyperram_edge_sync: 2-flop synchronizers plus CK edge and CS# rise/fall detection. It outputs edge strobes and aligned DQ/RWDS samples.

## Test plan
- Write 4 bytes 0x11, 0x22, 0x33, 0x44 to word 0x10, RWDS = 0 -> SRAM words 0x10 = 16'h1122 and 0x11 = 16'h3344, be = 2'b11. Readback returns the same bytes with RWDS toggling.
- Masked write to word 0x20 with RWDS 0,1 (old value 16'hAAAA, bytes 0x55, 0x66) -> exactly one request, be = 2'b10; word becomes 16'h55AA.
- Register read of word 0x000 -> DQ returns 0x0c, 0x81 after 4*LatencyClks latency edges; RWDS high during CA.
- Register write 16'h8f17 to word 0x800 -> cr0_o = 16'h8f17 with no SRAM request; a following register read returns 0x8f, 0x17.
- Read burst from word 2^AddrWidth-1, 2 words -> mem_addr sequence is FFFFF then 00000.
- CS# deasserted after 1 data byte of a read, then a new write issued -> all oe low within 3 clk_i; the next transaction decodes correctly. Same CS# abort after the upper byte of a write -> be = 2'b10 commit.

Source files
------------

// File: rtl/hyperram_responder_pkg.sv
// Shared types and constants for the HyperRAM responder: FSM states, CA field
// positions, register word addresses and the fixed latency multiplier.
package hyperram_responder_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCa,
    StLatency,
    StWdata,
    StRdata
  } state_e;

  localparam int unsigned CaRwBit    = 47;
  localparam int unsigned CaRegBit   = 46;
  localparam int unsigned CaBurstBit = 45;
  localparam int unsigned CaRowHi    = 44;
  localparam int unsigned CaRowLo    = 16;
  localparam int unsigned CaColHi    = 2;
  localparam int unsigned CaColLo    = 0;

  localparam logic [31:0] RegId0 = 32'h0000_0000;
  localparam logic [31:0] RegId1 = 32'h0000_0001;
  localparam logic [31:0] RegCr0 = 32'h0000_0800;

  // Latency is always doubled; each CK clock carries two edges.
  localparam int unsigned LatencyMult = 2;

endpackage

// File: rtl/hyperram_edge_sync.sv
// Two-flop synchronizer for CK/CS#/DQ/RWDS with CK edge and CS# rise detection.
// DQ/RWDS outputs are aligned with the CK sample that produced the edge strobe.
module hyperram_edge_sync (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ck_i,
  input  logic       cs_ni,
  input  logic [7:0] dq_i,
  input  logic       rwds_i,
  output logic       ck_edge_o,
  output logic       cs_active_o,
  output logic       cs_rise_o,
  output logic [7:0] dq_o,
  output logic       rwds_o
);

  // Vector layout: {ck, cs_n, rwds, dq[7:0]}; CS# resets deasserted.
  localparam logic [10:0] SyncIdle = {1'b0, 1'b1, 1'b0, 8'h00};

  logic [10:0] s1_q, s1_d, s2_q, s2_d;
  logic        ck_prev_q, ck_prev_d;
  logic        cs_n_prev_q, cs_n_prev_d;

  always_comb begin
    s1_d        = {ck_i, cs_ni, rwds_i, dq_i};
    s2_d        = s1_q;
    ck_prev_d   = s2_q[10];
    cs_n_prev_d = s2_q[9];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q        <= SyncIdle;
      s2_q        <= SyncIdle;
      ck_prev_q   <= 1'b0;
      cs_n_prev_q <= 1'b1;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      ck_prev_q   <= ck_prev_d;
      cs_n_prev_q <= cs_n_prev_d;
    end
  end

  assign ck_edge_o   = s2_q[10] ^ ck_prev_q;
  assign cs_active_o = ~s2_q[9];
  assign cs_rise_o   = s2_q[9] & ~cs_n_prev_q;
  assign rwds_o      = s2_q[8];
  assign dq_o        = s2_q[7:0];

endmodule

// File: rtl/hyperram_responder.sv
// HyperBus responder emulating one HyperRAM die: CA decode, fixed 2x latency,
// linear bursts into a single-port word SRAM, plus ID0/ID1/CR0 registers.
module hyperram_responder
  import hyperram_responder_pkg::*;
#(
  parameter int unsigned AddrWidth   = 20,
  parameter int unsigned LatencyClks = 6,
  parameter logic [15:0] Id0         = 16'h0c81,
  parameter logic [15:0] Id1         = 16'h0001,
  parameter logic [15:0] Cr0Reset    = 16'h8f1f
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 hyper_ck_i,
  input  logic                 hyper_cs_ni,
  input  logic [7:0]           hyper_dq_i,
  output logic [7:0]           hyper_dq_o,
  output logic                 hyper_dq_oe_o,
  input  logic                 hyper_rwds_i,
  output logic                 hyper_rwds_o,
  output logic                 hyper_rwds_oe_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [15:0]          mem_wdata_o,
  output logic [1:0]           mem_be_o,
  input  logic [15:0]          mem_rdata_i,
  output logic [15:0]          cr0_o
);

  localparam int unsigned LatEdges = 2 * LatencyMult * LatencyClks;
  localparam int unsigned LatW     = $clog2(LatEdges + 1);

  logic       ck_edge, cs_active, cs_rise, rwds_s;
  logic [7:0] dq_s;

  hyperram_edge_sync u_edge_sync (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .ck_i        (hyper_ck_i),
    .cs_ni       (hyper_cs_ni),
    .dq_i        (hyper_dq_i),
    .rwds_i      (hyper_rwds_i),
    .ck_edge_o   (ck_edge),
    .cs_active_o (cs_active),
    .cs_rise_o   (cs_rise),
    .dq_o        (dq_s),
    .rwds_o      (rwds_s)
  );

  state_e               state_q, state_d;
  logic [39:0]          ca_q, ca_d;
  logic [2:0]           ca_cnt_q, ca_cnt_d;
  logic [LatW-1:0]      lat_cnt_q, lat_cnt_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 is_read_q, is_read_d, is_reg_q, is_reg_d;
  logic                 phase_q, phase_d;
  logic [7:0]           whi_q, whi_d;
  logic                 mask_hi_q, mask_hi_d;
  logic [15:0]          rdata_q, rdata_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [15:0]          cr0_q, cr0_d;
  logic [7:0]           dq_q, dq_d;
  logic                 dq_oe_q, dq_oe_d, rwds_q, rwds_d, rwds_oe_q, rwds_oe_d;
  logic                 mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [AddrWidth-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]          mem_wdata_q, mem_wdata_d;
  logic [1:0]           mem_be_q, mem_be_d;

  logic [47:0]          ca_full;
  logic [31:0]          word_addr;
  logic                 wr_fire, rd_fire;
  logic [15:0]          wr_word;
  logic [1:0]           wr_be;
  logic [AddrWidth-1:0] rd_addr;

  assign ca_full   = {ca_q, dq_s};
  assign word_addr = {ca_full[CaRowHi:CaRowLo], ca_full[CaColHi:CaColLo]};

  // Burst type and the reserved CA bits carry nothing for this responder.
  logic unused_ca;
  assign unused_ca = ^{ca_full[CaBurstBit], ca_full[CaRowLo-1:CaColHi+1], word_addr};

  function automatic logic [15:0] reg_read(input logic [AddrWidth-1:0] a,
                                           input logic [15:0] cr0);
    logic [15:0] v;
    v = '0;
    if (a == RegId0[AddrWidth-1:0])      v = Id0;
    else if (a == RegId1[AddrWidth-1:0]) v = Id1;
    else if (a == RegCr0[AddrWidth-1:0]) v = cr0;
    return v;
  endfunction

  always_comb begin
    state_d     = state_q;
    ca_d        = ca_q;
    ca_cnt_d    = ca_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    addr_d      = addr_q;
    is_read_d   = is_read_q;
    is_reg_d    = is_reg_q;
    phase_d     = phase_q;
    whi_d       = whi_q;
    mask_hi_d   = mask_hi_q;
    rdata_d     = rdata_q;
    cr0_d       = cr0_q;
    dq_d        = dq_q;
    dq_oe_d     = dq_oe_q;
    rwds_d      = rwds_q;
    rwds_oe_d   = rwds_oe_q;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    rd_valid_d  = mem_req_q & ~mem_we_q;
    wr_fire     = 1'b0;
    wr_word     = {whi_q, dq_s};
    wr_be       = {~mask_hi_q, ~rwds_s};
    rd_fire     = 1'b0;
    rd_addr     = addr_q;

    if (rd_valid_q) rdata_d = mem_rdata_i;

    if (cs_rise) begin
      state_d    = StIdle;
      dq_d       = '0;
      dq_oe_d    = 1'b0;
      rwds_d     = 1'b0;
      rwds_oe_d  = 1'b0;
      rd_valid_d = 1'b0;
      // Half-written word: commit the captured upper byte only.
      if (state_q == StWdata && phase_q) begin
        wr_fire = 1'b1;
        wr_word = {whi_q, 8'h00};
        wr_be   = {~mask_hi_q, 1'b0};
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (cs_active) begin
            state_d   = StCa;
            ca_cnt_d  = '0;
            rwds_d    = 1'b1;
            rwds_oe_d = 1'b1;
            dq_oe_d   = 1'b0;
          end
        end
        StCa: begin
          if (ck_edge) begin
            ca_d     = ca_full[39:0];
            ca_cnt_d = ca_cnt_q + 3'd1;
            if (ca_cnt_q == 3'd5) begin
              addr_d    = word_addr[AddrWidth-1:0];
              is_read_d = ca_full[CaRwBit];
              is_reg_d  = ca_full[CaRegBit];
              phase_d   = 1'b0;
              lat_cnt_d = '0;
              rwds_d    = 1'b0;
              if (!ca_full[CaRwBit] && ca_full[CaRegBit]) begin
                state_d   = StWdata;
                rwds_oe_d = 1'b0;
              end else begin
                state_d   = StLatency;
                rwds_oe_d = ca_full[CaRwBit];
              end
            end
          end
        end
        StLatency: begin
          if (ck_edge) begin
            if (lat_cnt_q == LatW'(LatEdges - 1)) begin
              if (is_read_q) begin
                state_d = StRdata;
                rd_fire = 1'b1;
              end else begin
                state_d = StWdata;
              end
            end else begin
              lat_cnt_d = lat_cnt_q + 1'b1;
            end
          end
        end
        StWdata: begin
          if (ck_edge) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
              whi_d     = dq_s;
              mask_hi_d = rwds_s;
            end else begin
              wr_fire = 1'b1;
              addr_d  = addr_q + 1'b1;
            end
          end
        end
        StRdata: begin
          if (ck_edge) begin
            phase_d = ~phase_q;
            dq_oe_d = 1'b1;
            rwds_d  = ~phase_q;
            dq_d    = phase_q ? rdata_q[7:0] : rdata_q[15:8];
            if (phase_q) begin
              addr_d  = addr_q + 1'b1;
              rd_addr = addr_q + 1'b1;
              rd_fire = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (wr_fire) begin
      if (is_reg_q) begin
        if (addr_q == RegCr0[AddrWidth-1:0]) begin
          if (wr_be[1]) cr0_d[15:8] = wr_word[15:8];
          if (wr_be[0]) cr0_d[7:0]  = wr_word[7:0];
        end
      end else if (wr_be != 2'b00) begin
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = addr_q;
        mem_wdata_d = wr_word;
        mem_be_d    = wr_be;
      end
    end

    // Register reads resolve immediately; memory reads land one cycle later.
    if (rd_fire) begin
      if (is_reg_q) begin
        rdata_d = reg_read(rd_addr, cr0_q);
      end else begin
        mem_req_d  = 1'b1;
        mem_we_d   = 1'b0;
        mem_addr_d = rd_addr;
        mem_be_d   = 2'b11;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      ca_q        <= '0;
      ca_cnt_q    <= '0;
      lat_cnt_q   <= '0;
      addr_q      <= '0;
      is_read_q   <= 1'b0;
      is_reg_q    <= 1'b0;
      phase_q     <= 1'b0;
      whi_q       <= '0;
      mask_hi_q   <= 1'b0;
      rdata_q     <= '0;
      rd_valid_q  <= 1'b0;
      cr0_q       <= Cr0Reset;
      dq_q        <= '0;
      dq_oe_q     <= 1'b0;
      rwds_q      <= 1'b0;
      rwds_oe_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      ca_q        <= ca_d;
      ca_cnt_q    <= ca_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      addr_q      <= addr_d;
      is_read_q   <= is_read_d;
      is_reg_q    <= is_reg_d;
      phase_q     <= phase_d;
      whi_q       <= whi_d;
      mask_hi_q   <= mask_hi_d;
      rdata_q     <= rdata_d;
      rd_valid_q  <= rd_valid_d;
      cr0_q       <= cr0_d;
      dq_q        <= dq_d;
      dq_oe_q     <= dq_oe_d;
      rwds_q      <= rwds_d;
      rwds_oe_q   <= rwds_oe_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  assign hyper_dq_o      = dq_q;
  assign hyper_dq_oe_o   = dq_oe_q;
  assign hyper_rwds_o    = rwds_q;
  assign hyper_rwds_oe_o = rwds_oe_q;
  assign mem_req_o       = mem_req_q;
  assign mem_we_o        = mem_we_q;
  assign mem_addr_o      = mem_addr_q;
  assign mem_wdata_o     = mem_wdata_q;
  assign mem_be_o        = mem_be_q;
  assign cr0_o           = cr0_q;

endmodule

// File: tb/tb_hyperram_responder.sv
// Directed bench for hyperram_responder: drives HyperBus transactions with a
// 4-cycle CK half-period against a behavioural word SRAM and request log.
module tb_hyperram_responder;

  localparam int AW        = 20;
  localparam int LAT_EDGES = 24;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          hyper_ck_i = 1'b0;
  logic          hyper_cs_ni = 1'b1;
  logic [7:0]    hyper_dq_i = '0;
  logic          hyper_rwds_i = 1'b0;
  logic [7:0]    hyper_dq_o;
  logic          hyper_dq_oe_o, hyper_rwds_o, hyper_rwds_oe_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [15:0]   mem_wdata_o;
  logic [1:0]    mem_be_o;
  logic [15:0]   mem_rdata_i = '0;
  logic [15:0]   cr0_o;

  always #5 clk_i = ~clk_i;

  hyperram_responder dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .hyper_ck_i      (hyper_ck_i),
    .hyper_cs_ni     (hyper_cs_ni),
    .hyper_dq_i      (hyper_dq_i),
    .hyper_dq_o      (hyper_dq_o),
    .hyper_dq_oe_o   (hyper_dq_oe_o),
    .hyper_rwds_i    (hyper_rwds_i),
    .hyper_rwds_o    (hyper_rwds_o),
    .hyper_rwds_oe_o (hyper_rwds_oe_o),
    .mem_req_o       (mem_req_o),
    .mem_we_o        (mem_we_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_be_o        (mem_be_o),
    .mem_rdata_i     (mem_rdata_i),
    .cr0_o           (cr0_o)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
    logic [1:0]    be;
  } req_t;

  req_t        log_q[$];
  logic [15:0] sram [0:(1<<AW)-1];

  always @(posedge clk_i) begin
    if (mem_req_o) begin
      log_q.push_back('{we: mem_we_o, addr: mem_addr_o, wdata: mem_wdata_o, be: mem_be_o});
      if (mem_we_o) begin
        if (mem_be_o[1]) sram[mem_addr_o][15:8] <= mem_wdata_o[15:8];
        if (mem_be_o[0]) sram[mem_addr_o][7:0]  <= mem_wdata_o[7:0];
      end else begin
        mem_rdata_i <= sram[mem_addr_o];
      end
    end
  end

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] obs_dq;
  logic       obs_rwds, obs_dq_oe, obs_rwds_oe;
  logic       ca_rwds, ca_rwds_oe;
  logic       lat_rwds, lat_rwds_oe, lat_dq_oe;
  logic       end_dq_oe, end_rwds_oe;
  logic [7:0] rd_dq [8];
  logic       rd_rwds [8];
  logic       rd_oe [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("[TB] check %s observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One CK transition; data/RWDS lead CK by a cycle, outputs sampled 3 cycles later.
  task automatic ck_toggle(input logic [7:0] d, input logic r);
    hyper_dq_i   = d;
    hyper_rwds_i = r;
    @(posedge clk_i); #1;
    hyper_ck_i = ~hyper_ck_i;
    repeat (3) begin @(posedge clk_i); #1; end
    obs_dq      = hyper_dq_o;
    obs_rwds    = hyper_rwds_o;
    obs_dq_oe   = hyper_dq_oe_o;
    obs_rwds_oe = hyper_rwds_oe_o;
  endtask

  task automatic start_txn(input logic rd, input logic rg, input logic [31:0] wa);
    logic [47:0] ca;
    ca = {rd, rg, 1'b1, wa[31:3], 13'd0, wa[2:0]};
    hyper_ck_i  = 1'b0;
    hyper_cs_ni = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    for (int i = 5; i >= 0; i--) begin
      ck_toggle(ca[i*8 +: 8], 1'b0);
      if (i == 5) begin
        ca_rwds    = obs_rwds;
        ca_rwds_oe = obs_rwds_oe;
      end
    end
  endtask

  task automatic latency();
    for (int i = 0; i < LAT_EDGES; i++) ck_toggle(8'h00, 1'b0);
    lat_rwds    = obs_rwds;
    lat_rwds_oe = obs_rwds_oe;
    lat_dq_oe   = obs_dq_oe;
  endtask

  task automatic end_txn();
    @(posedge clk_i); #1;
    hyper_cs_ni = 1'b1;
    repeat (3) begin @(posedge clk_i); #1; end
    end_dq_oe    = hyper_dq_oe_o;
    end_rwds_oe  = hyper_rwds_oe_o;
    hyper_ck_i   = 1'b0;
    hyper_dq_i   = '0;
    hyper_rwds_i = 1'b0;
    repeat (6) @(posedge clk_i);
    #1;
  endtask

  task automatic do_write(input logic rg, input logic [31:0] wa, input int n,
                          input logic [31:0] d, input logic [3:0] m);
    start_txn(1'b0, rg, wa);
    if (!rg) latency();
    for (int i = 0; i < n; i++) ck_toggle(d[31-8*i -: 8], m[3-i]);
    end_txn();
  endtask

  task automatic do_read(input logic rg, input logic [31:0] wa, input int n);
    start_txn(1'b1, rg, wa);
    latency();
    for (int i = 0; i < n; i++) begin
      ck_toggle(8'h00, 1'b0);
      rd_dq[i]   = obs_dq;
      rd_rwds[i] = obs_rwds;
      rd_oe[i]   = obs_dq_oe;
    end
    end_txn();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_dq_oe", hyper_dq_oe_o, 0);
    check("rst_rwds_oe", hyper_rwds_oe_o, 0);
    check("rst_rwds", hyper_rwds_o, 0);
    check("rst_dq", hyper_dq_o, 0);
    check("rst_mem_req", mem_req_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_mem_be", mem_be_o, 0);
    check("rst_cr0", cr0_o, 16'h8f1f);
    rst_ni = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;

    // Plain 2-word write to 0x10
    log_q.delete();
    do_write(1'b0, 32'h10, 4, 32'h11223344, 4'b0000);
    check("wr_ca_rwds", ca_rwds, 1);
    check("wr_ca_rwds_oe", ca_rwds_oe, 1);
    check("wr_lat_rwds_oe", lat_rwds_oe, 0);
    check("wr_req_cnt", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      check("wr0_we", log_q[0].we, 1);
      check("wr0_addr", log_q[0].addr, 32'h10);
      check("wr0_data", log_q[0].wdata, 16'h1122);
      check("wr0_be", log_q[0].be, 2'b11);
      check("wr1_addr", log_q[1].addr, 32'h11);
      check("wr1_data", log_q[1].wdata, 16'h3344);
      check("wr1_be", log_q[1].be, 2'b11);
    end
    check("sram_10", sram[20'h10], 16'h1122);
    check("sram_11", sram[20'h11], 16'h3344);

    // Readback of 0x10
    do_read(1'b0, 32'h10, 4);
    check("rd_lat_rwds", lat_rwds, 0);
    check("rd_lat_rwds_oe", lat_rwds_oe, 1);
    check("rd_b0", rd_dq[0], 8'h11);
    check("rd_b1", rd_dq[1], 8'h22);
    check("rd_b2", rd_dq[2], 8'h33);
    check("rd_b3", rd_dq[3], 8'h44);
    check("rd_rwds_pat", {rd_rwds[0], rd_rwds[1], rd_rwds[2], rd_rwds[3]}, 4'b1010);
    check("rd_oe_pat", {rd_oe[0], rd_oe[1], rd_oe[2], rd_oe[3]}, 4'b1111);

    // Masked write: lower byte masked by RWDS
    do_write(1'b0, 32'h20, 2, 32'hAAAA0000, 4'b0000);
    log_q.delete();
    do_write(1'b0, 32'h20, 2, 32'h55660000, 4'b0100);
    check("mask_req_cnt", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      check("mask_be", log_q[0].be, 2'b10);
      check("mask_hi", log_q[0].wdata[15:8], 8'h55);
    end
    check("sram_20", sram[20'h20], 16'h55AA);

    // ID0 register read
    log_q.delete();
    do_read(1'b1, 32'h000, 2);
    check("id0_ca_rwds", ca_rwds, 1);
    check("id0_ca_rwds_oe", ca_rwds_oe, 1);
    check("id0_lat_dq_oe", lat_dq_oe, 0);
    check("id0_b0", rd_dq[0], 8'h0c);
    check("id0_b1", rd_dq[1], 8'h81);
    check("id0_rwds_pat", {rd_rwds[0], rd_rwds[1]}, 2'b10);
    check("id0_no_req", log_q.size(), 0);

    // CR0 register write (zero latency) and readback
    log_q.delete();
    do_write(1'b1, 32'h800, 2, 32'h8f170000, 4'b0000);
    check("cr0_val", cr0_o, 16'h8f17);
    check("cr0_no_req", log_q.size(), 0);
    do_read(1'b1, 32'h800, 2);
    check("cr0_b0", rd_dq[0], 8'h8f);
    check("cr0_b1", rd_dq[1], 8'h17);

    // Address wrap at the top of the SRAM
    log_q.delete();
    do_write(1'b0, 32'hFFFFF, 4, 32'hBEEFCAFE, 4'b0000);
    check("wrapw_cnt", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      check("wrapw_a0", log_q[0].addr, 32'hFFFFF);
      check("wrapw_a1", log_q[1].addr, 32'h00000);
    end
    log_q.delete();
    do_read(1'b0, 32'hFFFFF, 4);
    check("wrapr_cnt_ge2", log_q.size() >= 2, 1);
    if (log_q.size() >= 2) begin
      check("wrapr_we", log_q[0].we, 0);
      check("wrapr_a0", log_q[0].addr, 32'hFFFFF);
      check("wrapr_a1", log_q[1].addr, 32'h00000);
    end
    check("wrapr_b0", rd_dq[0], 8'hBE);
    check("wrapr_b1", rd_dq[1], 8'hEF);
    check("wrapr_b2", rd_dq[2], 8'hCA);
    check("wrapr_b3", rd_dq[3], 8'hFE);

    // Read aborted after one byte, then a fresh write
    do_read(1'b0, 32'h10, 1);
    check("abr_b0", rd_dq[0], 8'h11);
    check("abr_dq_oe", end_dq_oe, 0);
    check("abr_rwds_oe", end_rwds_oe, 0);
    do_write(1'b0, 32'h30, 2, 32'hA55A0000, 4'b0000);
    check("after_abr_sram", sram[20'h30], 16'hA55A);

    // Write aborted after the upper byte
    do_write(1'b0, 32'h40, 2, 32'h12340000, 4'b0000);
    log_q.delete();
    do_write(1'b0, 32'h40, 1, 32'h99000000, 4'b0000);
    check("abw_cnt", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      check("abw_addr", log_q[0].addr, 32'h40);
      check("abw_be", log_q[0].be, 2'b10);
      check("abw_hi", log_q[0].wdata[15:8], 8'h99);
    end
    check("abw_sram", sram[20'h40], 16'h9934);
    check("abw_dq_oe", end_dq_oe, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
